miriscv_lsu: RTL and testbench

Load/store unit between the miriscv core's execute stage and the data port of the RAM instantiated in miriscv_top. It takes one load/store request from the core and issues it to memory over a req/gnt/rvalid handshake. It generates byte enables and replicated write data, and returns sign- or zero-extended load data. The core is stalled until the access completes; misaligned requests, illegal sizes and grant timeouts are flagged.

---
 rtl/miriscv_lsu_pkg.sv | 41 ++++
 rtl/miriscv_lsu_align.sv | 71 +++++++
 rtl/miriscv_lsu.sv | 128 ++++++++++++
 tb/tb_miriscv_lsu.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_lsu_pkg.sv
// Shared definitions for the miriscv load/store unit: access size encodings,
// FSM state type and the request legality checks.
package miriscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2,
    RESP        = 2'd3
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      LDST_H, LDST_HU: mis = addr_lo[0];
      LDST_W:          mis = (addr_lo != 2'b00);
      default:         mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Unsigned sizes only make sense for loads; 3, 6 and 7 are unused funct3 codes.
  function automatic logic is_illegal(input logic [2:0] size, input logic we);
    logic ill;
    ill = 1'b0;
    case (size)
      LDST_B, LDST_H, LDST_W: ill = 1'b0;
      LDST_BU, LDST_HU:       ill = we;
      default:                ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/miriscv_lsu_align.sv
// Combinational lane logic: byte enables and write-data replication for the
// outgoing request, byte/half selection and extension for the returned word.
module miriscv_lsu_align
  import miriscv_lsu_pkg::*;
(
  input  logic [2:0]  req_size,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata_rep,
  input  logic [2:0]  rsp_size,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rsp_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Request side: lane enables and replicated store data
  always_comb begin
    req_be        = 4'b0000;
    req_wdata_rep = 32'd0;
    case (req_size)
      LDST_B, LDST_BU: begin
        req_be        = 4'b0001 << req_addr_lo;
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      LDST_H, LDST_HU: begin
        req_be        = 4'b0011 << req_addr_lo;
        req_wdata_rep = {2{req_wdata[15:0]}};
      end
      LDST_W: begin
        req_be        = 4'b1111;
        req_wdata_rep = req_wdata;
      end
      default: begin
        req_be        = 4'b0000;
        req_wdata_rep = 32'd0;
      end
    endcase
  end

  // Response side: pick the addressed lane and extend it to 32 bits
  always_comb begin
    byte_s   = 8'd0;
    half_s   = 16'd0;
    rsp_data = 32'd0;
    case (rsp_addr_lo)
      2'd0:    byte_s = rsp_rdata[7:0];
      2'd1:    byte_s = rsp_rdata[15:8];
      2'd2:    byte_s = rsp_rdata[23:16];
      2'd3:    byte_s = rsp_rdata[31:24];
      default: byte_s = 8'd0;
    endcase
    if (rsp_addr_lo[1]) begin
      half_s = rsp_rdata[31:16];
    end else begin
      half_s = rsp_rdata[15:0];
    end
    case (rsp_size)
      LDST_B:  rsp_data = {{24{byte_s[7]}}, byte_s};
      LDST_BU: rsp_data = {24'd0, byte_s};
      LDST_H:  rsp_data = {{16{half_s[15]}}, half_s};
      LDST_HU: rsp_data = {16'd0, half_s};
      LDST_W:  rsp_data = rsp_rdata;
      default: rsp_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// Load/store unit: accepts one core request, runs it over the req/gnt/rvalid
// data port and returns extended load data with done/err pulses.
module miriscv_lsu
  import miriscv_lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_size_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_wdata_i,
  output logic [31:0]       lsu_rdata_o,
  output logic              lsu_stall_o,
  output logic              lsu_done_o,
  output logic              lsu_err_o,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [31:0]       data_wdata_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [31:0]       data_rdata_i
);

  localparam int CNT_W = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GNT_TIMEOUT - 1);

  lsu_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       size_r;
  logic [1:0]       addr_lo_r;
  logic             resp_err_r;

  logic             check_fail_s;
  logic             accept_s;
  logic [3:0]       be_s;
  logic [31:0]      wdata_rep_s;
  logic [31:0]      rdata_ext_s;

  assign check_fail_s = is_misaligned(lsu_size_i, lsu_addr_i[1:0]) |
                        is_illegal(lsu_size_i, lsu_we_i);
  assign accept_s     = (state_r == IDLE) & lsu_req_i & ~check_fail_s;

  // A rejected request reports its error in the same cycle and never stalls.
  assign lsu_stall_o  = accept_s | (state_r == WAIT_GNT) | (state_r == WAIT_RVALID);
  assign lsu_err_o    = resp_err_r | ((state_r == IDLE) & lsu_req_i & check_fail_s);

  miriscv_lsu_align u_align (
    .req_size      (lsu_size_i),
    .req_addr_lo   (lsu_addr_i[1:0]),
    .req_wdata     (lsu_wdata_i),
    .req_be        (be_s),
    .req_wdata_rep (wdata_rep_s),
    .rsp_size      (size_r),
    .rsp_addr_lo   (addr_lo_r),
    .rsp_rdata     (data_rdata_i),
    .rsp_data      (rdata_ext_s)
  );

  // Access FSM with latched request fields, grant timeout and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      size_r       <= 3'd0;
      addr_lo_r    <= 2'd0;
      resp_err_r   <= 1'b0;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= 4'b0000;
      data_addr_o  <= '0;
      data_wdata_o <= 32'd0;
      lsu_done_o   <= 1'b0;
      lsu_rdata_o  <= 32'd0;
    end else begin
      lsu_done_o <= 1'b0;
      resp_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r      <= WAIT_GNT;
            cnt_r        <= '0;
            size_r       <= lsu_size_i;
            addr_lo_r    <= lsu_addr_i[1:0];
            data_req_o   <= 1'b1;
            data_we_o    <= lsu_we_i;
            data_be_o    <= be_s;
            data_addr_o  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
            data_wdata_o <= wdata_rep_s;
          end
        end
        WAIT_GNT: begin
          if (data_gnt_i) begin
            state_r    <= WAIT_RVALID;
            data_req_o <= 1'b0;
            cnt_r      <= '0;
          end else if (cnt_r == CNT_LAST) begin
            state_r    <= RESP;
            data_req_o <= 1'b0;
            resp_err_r <= 1'b1;
            cnt_r      <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        WAIT_RVALID: begin
          if (data_rvalid_i) begin
            state_r     <= RESP;
            lsu_done_o  <= 1'b1;
            lsu_rdata_o <= data_we_o ? 32'd0 : rdata_ext_s;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Self-checking bench for miriscv_lsu: a negedge memory responder with
// programmable grant delay, and a scoreboard of expected completions.
module tb_miriscv_lsu;
  import miriscv_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        lsu_req_i, lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
  logic        lsu_stall_o, lsu_done_o, lsu_err_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_gnt_i, data_rvalid_i;
  logic [31:0] data_rdata_i;

  always #5 clk = ~clk;

  miriscv_lsu #(.ADDR_W(32), .GNT_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_rdata_o(lsu_rdata_o),
    .lsu_stall_o(lsu_stall_o), .lsu_done_o(lsu_done_o), .lsu_err_o(lsu_err_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  typedef struct {
    logic        done;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        stall0, err0, req_seen, we, done, err, stall_end, req_after, err_after;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    int          cyc;
  } obs_t;

  localparam logic [2:0] SZ_TAB [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_mis = 0;

  logic [31:0] mem [0:63];
  logic        auto_mode;
  int          gnt_delay;
  int          wait_cnt;
  logic        rv_pending;
  logic [5:0]  rv_idx;

  // Memory responder: grant after gnt_delay request cycles, rvalid the cycle after grant
  always @(negedge clk) begin
    if (auto_mode) begin
      data_rvalid_i = rv_pending;
      if (rv_pending) data_rdata_i = mem[rv_idx];
      rv_pending = 1'b0;
      data_gnt_i = 1'b0;
      if (data_req_o) begin
        if (wait_cnt >= gnt_delay) begin
          data_gnt_i = 1'b1;
          wait_cnt   = 0;
          rv_pending = 1'b1;
          rv_idx     = data_addr_o[7:2];
          if (data_we_o)
            for (int b = 0; b < 4; b++)
              if (data_be_o[b]) mem[rv_idx][8*b +: 8] = data_wdata_o[8*b +: 8];
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  function automatic logic [31:0] ref_load(input logic [2:0] size, input logic [1:0] off, input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * off);
    case (size)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'd0, 3'd4: return 4'b0001 << off;
      3'd1, 3'd5: return 4'b0011 << off;
      default:    return 4'b1111;
    endcase
  endfunction

  task automatic run_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input int gdelay, output obs_t o);
    int n;
    bit fin;
    o = '{default: 0};
    n = 0;
    fin = 1'b0;
    gnt_delay = gdelay;
    @(negedge clk);
    lsu_we_i = we; lsu_size_i = size; lsu_addr_i = addr; lsu_wdata_i = wdata; lsu_req_i = 1'b1;
    #1;
    o.stall0 = lsu_stall_o;
    o.err0   = lsu_err_o;
    if (o.err0) begin
      o.err = 1'b1;
      @(posedge clk);
      #1 lsu_req_i = 1'b0;
      @(negedge clk);
      o.req_seen  = data_req_o;
      o.err_after = lsu_err_o | lsu_done_o;
    end else begin
      while (!fin && n < 100) begin
        @(negedge clk);
        n++;
        if (data_req_o && !o.req_seen) begin
          o.req_seen = 1'b1; o.we = data_we_o; o.be = data_be_o;
          o.addr = data_addr_o; o.wdata = data_wdata_o;
        end
        if (lsu_done_o || lsu_err_o) begin
          fin = 1'b1; o.done = lsu_done_o; o.err = lsu_err_o;
          o.rdata = lsu_rdata_o; o.stall_end = lsu_stall_o;
        end
      end
      o.cyc = fin ? n : -1;
      lsu_req_i = 1'b0;
      @(negedge clk);
      o.req_after = data_req_o;
      o.err_after = lsu_err_o | lsu_done_o;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'd0;
    lsu_addr_i = 32'd0; lsu_wdata_i = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    n_cmp++; if (data_req_o !== 1'b0) begin n_mis++; $display("FAIL rst_req: got %b want 0", data_req_o); end
    n_cmp++; if (data_we_o !== 1'b0) begin n_mis++; $display("FAIL rst_we: got %b want 0", data_we_o); end
    n_cmp++; if (data_be_o !== 4'b0000) begin n_mis++; $display("FAIL rst_be: got %b want 0000", data_be_o); end
    n_cmp++; if (data_addr_o !== 32'd0) begin n_mis++; $display("FAIL rst_addr: got %h want 0", data_addr_o); end
    n_cmp++; if (data_wdata_o !== 32'd0) begin n_mis++; $display("FAIL rst_wdata: got %h want 0", data_wdata_o); end
    n_cmp++; if (lsu_done_o !== 1'b0) begin n_mis++; $display("FAIL rst_done: got %b want 0", lsu_done_o); end
    n_cmp++; if (lsu_err_o !== 1'b0) begin n_mis++; $display("FAIL rst_err: got %b want 0", lsu_err_o); end
    n_cmp++; if (lsu_rdata_o !== 32'd0) begin n_mis++; $display("FAIL rst_rdata: got %h want 0", lsu_rdata_o); end
    n_cmp++; if (lsu_stall_o !== 1'b0) begin n_mis++; $display("FAIL rst_stall: got %b want 0", lsu_stall_o); end
  endtask

  task automatic test_load_word();
    obs_t o; exp_t e;
    mem[4] = 32'h8765_4321;
    sb.push_back('{1'b1, 1'b0, 32'h8765_4321, 3});
    run_access(1'b0, LDST_W, 32'h10, 32'd0, 0, o);
    e = sb.pop_front();
    n_cmp++; if (o.stall0 !== 1'b1) begin n_mis++; $display("FAIL ldw_stall_accept: got %b want 1", o.stall0); end
    n_cmp++; if (o.be !== 4'b1111) begin n_mis++; $display("FAIL ldw_be: got %b want 1111", o.be); end
    n_cmp++; if (o.addr !== 32'h10) begin n_mis++; $display("FAIL ldw_addr: got %h want 10", o.addr); end
    n_cmp++; if (o.we !== 1'b0) begin n_mis++; $display("FAIL ldw_we: got %b want 0", o.we); end
    n_cmp++; if (o.done !== e.done || o.err !== e.err) begin n_mis++; $display("FAIL ldw_done_err: got %b/%b want %b/%b", o.done, o.err, e.done, e.err); end
    n_cmp++; if (o.rdata !== e.rdata) begin n_mis++; $display("FAIL ldw_rdata: got %h want %h", o.rdata, e.rdata); end
    n_cmp++; if (o.cyc !== e.cyc) begin n_mis++; $display("FAIL ldw_latency: got %0d want %0d", o.cyc, e.cyc); end
    n_cmp++; if (o.stall_end !== 1'b0) begin n_mis++; $display("FAIL ldw_stall_resp: got %b want 0", o.stall_end); end
    n_cmp++; if (o.err_after !== 1'b0) begin n_mis++; $display("FAIL ldw_pulse_width: got %b want 0", o.err_after); end
  endtask

  task automatic test_load_byte();
    obs_t o; exp_t e;
    mem[4] = 32'h80FF_0000;
    sb.push_back('{1'b1, 1'b0, 32'hFFFF_FF80, 3});
    run_access(1'b0, LDST_B, 32'h13, 32'd0, 0, o);
    e = sb.pop_front();
    n_cmp++; if (o.be !== 4'b1000) begin n_mis++; $display("FAIL ldb_be: got %b want 1000", o.be); end
    n_cmp++; if (o.addr !== 32'h10) begin n_mis++; $display("FAIL ldb_addr: got %h want 10", o.addr); end
    n_cmp++; if (o.done !== e.done || o.rdata !== e.rdata) begin n_mis++; $display("FAIL ldb_rdata: got %b/%h want %b/%h", o.done, o.rdata, e.done, e.rdata); end
    sb.push_back('{1'b1, 1'b0, 32'h0000_0080, 3});
    run_access(1'b0, LDST_BU, 32'h13, 32'd0, 0, o);
    e = sb.pop_front();
    n_cmp++; if (o.done !== e.done || o.rdata !== e.rdata) begin n_mis++; $display("FAIL ldbu_rdata: got %b/%h want %b/%h", o.done, o.rdata, e.done, e.rdata); end
  endtask

  task automatic test_store();
    obs_t o; exp_t e;
    sb.push_back('{1'b1, 1'b0, 32'd0, 3});
    run_access(1'b1, LDST_H, 32'h12, 32'hDEAD_BEEF, 0, o);
    e = sb.pop_front();
    n_cmp++; if (o.we !== 1'b1) begin n_mis++; $display("FAIL sth_we: got %b want 1", o.we); end
    n_cmp++; if (o.be !== 4'b1100) begin n_mis++; $display("FAIL sth_be: got %b want 1100", o.be); end
    n_cmp++; if (o.wdata !== 32'hBEEF_BEEF) begin n_mis++; $display("FAIL sth_wdata: got %h want beefbeef", o.wdata); end
    n_cmp++; if (o.done !== e.done || o.rdata !== e.rdata || o.cyc !== e.cyc) begin n_mis++; $display("FAIL sth_done: got %b/%h/%0d want %b/%h/%0d", o.done, o.rdata, o.cyc, e.done, e.rdata, e.cyc); end
    sb.push_back('{1'b1, 1'b0, 32'hBEEF_0000, 3});
    run_access(1'b0, LDST_W, 32'h10, 32'd0, 0, o);
    e = sb.pop_front();
    n_cmp++; if (o.rdata !== e.rdata) begin n_mis++; $display("FAIL sth_readback: got %h want %h", o.rdata, e.rdata); end
    sb.push_back('{1'b1, 1'b0, 32'd0, 4});
    run_access(1'b1, LDST_B, 32'h21, 32'h1234_56A5, 1, o);
    e = sb.pop_front();
    n_cmp++; if (o.be !== 4'b0010 || o.wdata !== 32'hA5A5_A5A5) begin n_mis++; $display("FAIL stb_lanes: got %b/%h want 0010/a5a5a5a5", o.be, o.wdata); end
    n_cmp++; if (o.done !== e.done || o.cyc !== e.cyc) begin n_mis++; $display("FAIL stb_done: got %b/%0d want %b/%0d", o.done, o.cyc, e.done, e.cyc); end
  endtask

  task automatic test_errors();
    obs_t o; exp_t e;
    logic        we_tab [6];
    logic [2:0]  sz_tab [6];
    logic [31:0] ad_tab [6];
    we_tab = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    sz_tab = '{LDST_W, LDST_BU, LDST_H, 3'd3, LDST_HU, 3'd7};
    ad_tab = '{32'h11, 32'h10, 32'h13, 32'h10, 32'h10, 32'h0};
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{1'b0, 1'b1, 32'd0, 0});
      run_access(we_tab[i], sz_tab[i], ad_tab[i], 32'hFFFF_FFFF, 0, o);
      e = sb.pop_front();
      n_cmp++; if (o.err0 !== e.err || o.stall0 !== 1'b0) begin n_mis++; $display("FAIL err_imm[%0d]: got err=%b stall=%b want err=%b stall=0", i, o.err0, o.stall0, e.err); end
      n_cmp++; if (o.req_seen !== 1'b0 || o.err_after !== 1'b0) begin n_mis++; $display("FAIL err_noreq[%0d]: got req=%b err_after=%b want 0/0", i, o.req_seen, o.err_after); end
    end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    sb.push_back('{1'b0, 1'b1, 32'd0, 17});
    run_access(1'b0, LDST_W, 32'h10, 32'd0, 1000, o);
    e = sb.pop_front();
    n_cmp++; if (o.err !== e.err || o.done !== e.done) begin n_mis++; $display("FAIL tmo_flags: got err=%b done=%b want %b/%b", o.err, o.done, e.err, e.done); end
    n_cmp++; if (o.cyc !== e.cyc) begin n_mis++; $display("FAIL tmo_latency: got %0d want %0d", o.cyc, e.cyc); end
    n_cmp++; if (o.req_seen !== 1'b1 || o.req_after !== 1'b0) begin n_mis++; $display("FAIL tmo_req: got seen=%b after=%b want 1/0", o.req_seen, o.req_after); end
    sb.push_back('{1'b1, 1'b0, 32'hBEEF_0000, 6});
    run_access(1'b0, LDST_W, 32'h10, 32'd0, 3, o);
    e = sb.pop_front();
    n_cmp++; if (o.done !== e.done || o.err !== e.err || o.rdata !== e.rdata || o.cyc !== e.cyc) begin n_mis++; $display("FAIL gnt3_load: got %b/%b/%h/%0d want %b/%b/%h/%0d", o.done, o.err, o.rdata, o.cyc, e.done, e.err, e.rdata, e.cyc); end
  endtask

  task automatic test_sweep();
    obs_t o; exp_t e;
    logic [31:0] w;
    logic [2:0]  sz;
    logic        legal;
    int          gd;
    w = $urandom;
    mem[8] = w;
    for (int off = 0; off < 4; off++) begin
      for (int k = 0; k < 8; k++) begin
        sz = SZ_TAB[k];
        gd = $urandom_range(0, 2);
        legal = (k < 5) && !((sz == 3'd1 || sz == 3'd5) && off[0]) && !(sz == 3'd2 && off != 0);
        sb.push_back('{legal, !legal, legal ? ref_load(sz, 2'(off), w) : 32'd0, legal ? 3 + gd : 0});
        run_access(1'b0, sz, 32'h20 + 32'(off), 32'd0, gd, o);
        e = sb.pop_front();
        n_cmp++; if (o.done !== e.done || o.err !== e.err || o.cyc !== e.cyc) begin n_mis++; $display("FAIL sweep_flags sz=%0d off=%0d: got %b/%b/%0d want %b/%b/%0d", sz, off, o.done, o.err, o.cyc, e.done, e.err, e.cyc); end
        if (legal) begin
          n_cmp++; if (o.rdata !== e.rdata) begin n_mis++; $display("FAIL sweep_rdata sz=%0d off=%0d: got %h want %h", sz, off, o.rdata, e.rdata); end
          n_cmp++; if (o.be !== ref_be(sz, 2'(off))) begin n_mis++; $display("FAIL sweep_be sz=%0d off=%0d: got %b want %b", sz, off, o.be, ref_be(sz, 2'(off))); end
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    obs_t o; exp_t e;
    auto_mode = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    @(negedge clk);
    lsu_we_i = 1'b0; lsu_size_i = LDST_W; lsu_addr_i = 32'h10; lsu_req_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (data_req_o !== 1'b1) begin n_mis++; $display("FAIL rmid_req: got %b want 1", data_req_o); end
    data_gnt_i = 1'b1;
    @(negedge clk);
    data_gnt_i = 1'b0;
    n_cmp++; if (data_req_o !== 1'b0 || lsu_stall_o !== 1'b1) begin n_mis++; $display("FAIL rmid_wait: got req=%b stall=%b want 0/1", data_req_o, lsu_stall_o); end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0; lsu_req_i = 1'b0;
    data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678;
    #1;
    n_cmp++; if ({data_req_o, data_we_o, data_be_o} !== 6'd0 || data_addr_o !== 32'd0 || data_wdata_o !== 32'd0) begin n_mis++; $display("FAIL rmid_bus: got req=%b we=%b be=%b addr=%h wdata=%h want all 0", data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o); end
    n_cmp++; if (lsu_stall_o !== 1'b0 || lsu_rdata_o !== 32'd0) begin n_mis++; $display("FAIL rmid_core: got stall=%b rdata=%h want 0/0", lsu_stall_o, lsu_rdata_o); end
    @(negedge clk);
    data_rvalid_i = 1'b0;
    n_cmp++; if (lsu_done_o !== 1'b0 || lsu_err_o !== 1'b0 || lsu_rdata_o !== 32'd0) begin n_mis++; $display("FAIL rmid_ignore: got done=%b err=%b rdata=%h want 0/0/0", lsu_done_o, lsu_err_o, lsu_rdata_o); end
    rv_pending = 1'b0; wait_cnt = 0; auto_mode = 1'b1;
    sb.push_back('{1'b1, 1'b0, 32'hBEEF_0000, 3});
    run_access(1'b0, LDST_W, 32'h10, 32'd0, 0, o);
    e = sb.pop_front();
    n_cmp++; if (o.done !== e.done || o.rdata !== e.rdata || o.cyc !== e.cyc) begin n_mis++; $display("FAIL rmid_recover: got %b/%h/%0d want %b/%h/%0d", o.done, o.rdata, o.cyc, e.done, e.rdata, e.cyc); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    auto_mode = 1'b1; gnt_delay = 0; wait_cnt = 0; rv_pending = 1'b0; rv_idx = 6'd0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'd0;
    test_reset();
    test_load_word();
    test_load_byte();
    test_store();
    test_errors();
    test_timeout();
    test_sweep();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
